// File: rtl/conv_window_streamer_pkg.sv
// Shared constants and types for the 3x3 window operand streamer.
package conv_window_streamer_pkg;

  // Operand word width (FP16).
  localparam int unsigned BitLength = 16;
  // Taps in a 3x3 window.
  localparam int unsigned WinTaps = 9;
  // Interleaved pixel/weight words per window.
  localparam int unsigned WordsPerWin = 18;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEmit,
    StDone
  } state_e;

endpackage

// File: rtl/conv_window_streamer_window_shift_reg.sv
// Pixel shift register spanning two image rows plus three pixels; exposes the 3x3 window taps.
module window_shift_reg
  import conv_window_streamer_pkg::*;
#(
  parameter int unsigned ImgWidth = 8,
  parameter int unsigned Depth    = 2 * ImgWidth + 3,
  parameter int unsigned Width    = BitLength
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            shift_en_i,
  input  logic [Width-1:0]                data_i,
  output logic [WinTaps-1:0][Width-1:0]   taps_o
);

  logic [Depth-1:0][Width-1:0] sr_q;

  // Newest pixel enters at index 0; older pixels move toward higher indices.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (shift_en_i) begin
      sr_q <= {sr_q[Depth-2:0], data_i};
    end
  end

  // Tap (dr,dc) sits (2-dr) rows and (2-dc) pixels behind the newest pixel.
  for (genvar dr = 0; dr < 3; dr++) begin : g_row
    for (genvar dc = 0; dc < 3; dc++) begin : g_col
      assign taps_o[3*dr+dc] = sr_q[(2-dr)*ImgWidth + (2-dc)];
    end
  end

endmodule

// File: rtl/conv_window_streamer.sv
// Streams every valid 3x3 window of an FP16 image as interleaved pixel/weight operand words.
module conv_window_streamer
  import conv_window_streamer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 wLoad,
  input  logic [BitLength-1:0] wData,
  input  logic                 frameStart,
  input  logic                 pixValid,
  input  logic [BitLength-1:0] pixData,
  output logic                 pixReady,
  output logic [BitLength-1:0] outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 winStart,
  output logic                 frameDone,
  output logic                 busy
);

  localparam int unsigned ColW  = $clog2(IMG_WIDTH);
  localparam int unsigned RowW  = $clog2(IMG_HEIGHT);
  localparam int unsigned NW    = $clog2(WordsPerWin);
  localparam int unsigned WIdxW = $clog2(WinTaps);

  state_e                              state_q, state_d;
  logic   [WinTaps-1:0][BitLength-1:0] k_q;
  logic   [WIdxW-1:0]                  w_idx_q;
  logic   [ColW-1:0]                   col_q;
  logic   [RowW-1:0]                   row_q;
  logic   [NW-1:0]                     n_q;
  logic                                last_q;
  logic                                win_start_q;
  logic   [WinTaps-1:0][BitLength-1:0] taps;
  logic   [NW-2:0]                     tap_sel;
  logic                                pix_acc, out_acc, win_pix, last_pix, col_wrap, n_last;

  assign pix_acc  = pixValid && (state_q == StFill);
  assign out_acc  = outReady && (state_q == StEmit);
  assign win_pix  = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
  assign col_wrap = (col_q == ColW'(IMG_WIDTH - 1));
  assign last_pix = (row_q == RowW'(IMG_HEIGHT - 1)) && col_wrap;
  assign n_last   = (n_q == NW'(WordsPerWin - 1));
  assign tap_sel  = n_q[NW-1:1];

  window_shift_reg #(
    .ImgWidth(IMG_WIDTH),
    .Depth   (2 * IMG_WIDTH + 3),
    .Width   (BitLength)
  ) u_window_shift_reg (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .shift_en_i(pix_acc),
    .data_i    (pixData),
    .taps_o    (taps)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (frameStart) state_d = StFill;
      StFill: if (pix_acc && win_pix) state_d = StEmit;
      StEmit: if (out_acc && n_last) state_d = last_q ? StDone : StFill;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Kernel store; writes only while idle, index wraps after the ninth tap.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      k_q     <= '0;
      w_idx_q <= '0;
    end else if ((state_q == StIdle) && wLoad) begin
      k_q[w_idx_q] <= wData;
      w_idx_q      <= (w_idx_q == WIdxW'(WinTaps - 1)) ? '0 : w_idx_q + 1'b1;
    end
  end

  // Pixel position counters plus flags describing the pixel just accepted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      win_start_q <= 1'b0;
    end else begin
      win_start_q <= pix_acc && win_pix;
      if ((state_q == StIdle) && frameStart) begin
        col_q <= '0;
        row_q <= '0;
      end else if (pix_acc) begin
        last_q <= last_pix;
        if (col_wrap) begin
          col_q <= '0;
          row_q <= (row_q == RowW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Word counter within a window; advances only on a downstream handshake.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      n_q <= '0;
    end else if (out_acc) begin
      n_q <= n_last ? '0 : n_q + 1'b1;
    end
  end

  // Outputs decoded from state; everything is zero while idle or in reset.
  always_comb begin
    pixReady  = (state_q == StFill);
    busy      = (state_q != StIdle);
    frameDone = (state_q == StDone);
    outValid  = 1'b0;
    outData   = '0;
    winStart  = 1'b0;
    if (state_q == StEmit) begin
      outValid = 1'b1;
      outData  = n_q[0] ? k_q[tap_sel] : taps[tap_sel];
      winStart = win_start_q;
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer on a 4x4 frame.
module tb_conv_window_streamer;
  import conv_window_streamer_pkg::*;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int NWIN   = (W - 2) * (H - 2);
  localparam int NWORDS = NWIN * WordsPerWin;

  logic                 Clk, Rst, wLoad, frameStart, pixValid, pixReady;
  logic                 outValid, outReady, winStart, frameDone, busy;
  logic [BitLength-1:0] wData, pixData, outData;

  conv_window_streamer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .wLoad     (wLoad),
    .wData     (wData),
    .frameStart(frameStart),
    .pixValid  (pixValid),
    .pixData   (pixData),
    .pixReady  (pixReady),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .winStart  (winStart),
    .frameDone (frameDone),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] words[$];
  int ws_cnt = 0;
  int fd_cnt = 0;
  logic [15:0] kern[9];

  typedef struct {
    int first_tap;
    int last_tap;
  } win_vec_t;
  win_vec_t win_tab[NWIN];

  // Inputs change #1 after posedge, so the negedge sees what the next posedge will sample.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (outValid && outReady) words.push_back(outData);
      if (winStart) ws_cnt++;
      if (frameDone) fd_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int i);
    int w, n, t, r0, c0;
    w  = i / WordsPerWin;
    n  = i % WordsPerWin;
    t  = n / 2;
    r0 = w / (W - 2);
    c0 = w % (W - 2);
    if (n % 2 == 1) return kern[t];
    return 16'(32'h1000 + (r0 + t / 3) * W + c0 + t % 3);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_kernel(input bit with_start);
    for (int i = 0; i < 9; i++) begin
      wLoad = 1'b1;
      wData = kern[i];
      if (with_start && i == 8) frameStart = 1'b1;
      tick();
      wLoad      = 1'b0;
      frameStart = 1'b0;
    end
  endtask

  task automatic push_pix(input logic [15:0] d);
    pixValid = 1'b1;
    pixData  = d;
    for (int t = 0; t < 200; t++) begin
      if (pixReady) begin
        tick();
        pixValid = 1'b0;
        return;
      end
      tick();
    end
    pixValid = 1'b0;
    chk("pix_accept_timeout", 0, 1);
  endtask

  task automatic start_frame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic wait_done(input int fd0);
    for (int t = 0; t < 400; t++) begin
      if (fd_cnt > fd0) break;
      tick();
    end
    chk("frame_done_count", fd_cnt - fd0, 1);
    tick();
    chk("busy_after_done", busy, 0);
  endtask

  task automatic check_stream(input int base, input int ws0);
    logic [15:0] a;
    chk("stream_length", words.size() - base, NWORDS);
    chk("win_start_count", ws_cnt - ws0, NWIN);
    for (int i = 0; i < NWORDS; i++) begin
      a = (base + i < words.size()) ? words[base + i] : 16'hxxxx;
      chk($sformatf("word[%0d]", i), a, exp_word(i));
    end
  endtask

  initial begin
    int base, ws0, fd0;
    Rst = 1'b1; wLoad = 1'b0; wData = '0; frameStart = 1'b0;
    pixValid = 1'b0; pixData = '0; outReady = 1'b1;
    for (int i = 0; i < 9; i++) kern[i] = 16'h3C00 + 16'(i * 256);
    win_tab[0] = '{0, 10};
    win_tab[1] = '{1, 11};
    win_tab[2] = '{4, 14};
    win_tab[3] = '{5, 15};

    // Reset state.
    repeat (3) tick();
    chk("rst_outValid", outValid, 0);
    chk("rst_outData", outData, 0);
    chk("rst_winStart", winStart, 0);
    chk("rst_frameDone", frameDone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pixReady", pixReady, 0);
    Rst = 1'b0;
    tick();

    // Kernel load with frameStart sharing the last weight cycle, then a full frame.
    base = words.size(); ws0 = ws_cnt; fd0 = fd_cnt;
    load_kernel(1'b1);
    chk("fill_after_start_busy", busy, 1);
    chk("fill_after_start_ready", pixReady, 1);
    for (int i = 0; i < W * H; i++) push_pix(16'h1000 + 16'(i));
    wait_done(fd0);
    check_stream(base, ws0);
    for (int w = 0; w < NWIN; w++) begin
      chk($sformatf("win%0d_first", w), words[base + w * WordsPerWin],
          16'h1000 + 16'(win_tab[w].first_tap));
      chk($sformatf("win%0d_last", w), words[base + w * WordsPerWin + 16],
          16'h1000 + 16'(win_tab[w].last_tap));
    end

    // First-word latency and back-pressure at word 7; kernel retained from previous frame.
    base = words.size(); ws0 = ws_cnt; fd0 = fd_cnt;
    start_frame();
    for (int i = 0; i <= 10; i++) push_pix(16'h1000 + 16'(i));
    chk("lat_outValid", outValid, 1);
    chk("lat_winStart", winStart, 1);
    chk("lat_outData", outData, 16'h1000);
    chk("lat_pixReady", pixReady, 0);
    tick();
    chk("winStart_one_cycle", winStart, 0);
    repeat (6) tick();
    outReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      chk("bp_outValid", outValid, 1);
      chk("bp_outData", outData, exp_word(7));
      chk("bp_pixReady", pixReady, 0);
    end
    @(posedge Clk);
    #1;
    outReady = 1'b1;
    for (int i = 11; i < W * H; i++) push_pix(16'h1000 + 16'(i));
    wait_done(fd0);
    check_stream(base, ws0);

    // Illegal wLoad/frameStart during FILL and EMIT must not disturb anything.
    base = words.size(); ws0 = ws_cnt; fd0 = fd_cnt;
    start_frame();
    wLoad = 1'b1; wData = 16'hFFFF; frameStart = 1'b1;
    push_pix(16'h1000);
    wLoad = 1'b0; frameStart = 1'b0;
    for (int i = 1; i <= 10; i++) push_pix(16'h1000 + 16'(i));
    chk("illegal_in_emit", outValid, 1);
    wLoad = 1'b1; wData = 16'hFFFF; frameStart = 1'b1;
    tick();
    wLoad = 1'b0; frameStart = 1'b0;
    for (int i = 11; i < W * H; i++) push_pix(16'h1000 + 16'(i));
    wait_done(fd0);
    check_stream(base, ws0);

    // A fresh reload must land at tap 0, showing the weight index was left alone.
    for (int i = 0; i < 9; i++) kern[i] = 16'h4800 + 16'(i * 3);
    base = words.size(); ws0 = ws_cnt; fd0 = fd_cnt;
    load_kernel(1'b0);
    start_frame();
    for (int i = 0; i < W * H; i++) push_pix(16'h1000 + 16'(i));
    wait_done(fd0);
    check_stream(base, ws0);

    // Reset at word 9 of the first window, then reload and replay the golden frame.
    start_frame();
    for (int i = 0; i <= 10; i++) push_pix(16'h1000 + 16'(i));
    repeat (9) tick();
    Rst = 1'b1;
    #1;
    chk("rst_mid_outValid", outValid, 0);
    chk("rst_mid_outData", outData, 0);
    chk("rst_mid_winStart", winStart, 0);
    chk("rst_mid_pixReady", pixReady, 0);
    chk("rst_mid_busy", busy, 0);
    tick();
    Rst = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) kern[i] = 16'h3C00 + 16'(i * 256);
    base = words.size(); ws0 = ws_cnt; fd0 = fd_cnt;
    load_kernel(1'b0);
    start_frame();
    for (int i = 0; i < W * H; i++) push_pix(16'h1000 + 16'(i));
    wait_done(fd0);
    check_stream(base, ws0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
